// File: rtl/cameralink_pkg.sv
// cameralink_pkg: shared types and helpers for the CameraLink capture path.
// Holds the capture state encoding and the saturating counter increment.
// Pure declarations; no logic of its own.
package cameralink_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } cap_state_e;

  // Increment v, holding at 2^w-1 instead of wrapping (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [63:0] lim;
    lim = (64'd1 << w) - 64'd1;
    if ({32'd0, v} >= lim) begin
      return v;
    end
    return v + 32'd1;
  endfunction

endpackage

// File: rtl/simbus_sync_fifo.sv
// simbus_sync_fifo: single-clock FIFO with full/empty flags and register-array storage.
// Latency: a push into an empty FIFO is visible at the head on the next cycle.
// Backpressure: a push while full is accepted only if a pop happens in the same cycle.
module simbus_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_dat_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o   = (count_q == (AW+1)'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign pop_ok   = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign push_ok  = push_i & (~full_o | pop_ok);
  assign rd_dat_o = mem_q[rd_ptr_q];

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_dat_i;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cameralink_capture.sv
// cameralink_capture: arms the camera, qualifies FVV/LVV/VCE beats and buffers them with sof/eol markers.
// Latency: each beat waits in a one-beat skid stage, then one cycle in the FIFO before out_valid.
// Backpressure: out_ready stalls the FIFO; a push while full drops the beat and sets sticky overflow.
module cameralink_capture
  import cameralink_pkg::*;
#(
  parameter int TAPS  = 1,
  parameter int BITS  = 8,
  parameter int DEPTH = 16,
  parameter int CW    = 16
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 FVV,
  input  logic                 LVV,
  input  logic                 VCE,
  input  logic [TAPS*BITS-1:0] pix_in,
  input  logic                 arm,
  input  logic                 continuous,
  output logic                 cam_enable,
  output logic                 cam_request,
  output logic [TAPS*BITS-1:0] out_data,
  output logic                 out_sof,
  output logic                 out_eol,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_done,
  output logic [CW-1:0]        line_count,
  output logic [CW-1:0]        beat_count,
  output logic                 overflow
);
  localparam int DW = TAPS * BITS;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sof;
    logic          eol;
  } beat_t;

  cap_state_e    state_q;
  logic          fvv_q;          // FVV_d
  logic          lvv_q;          // LVV_d
  logic          skid_vld_q;
  logic [DW-1:0] skid_dat_q;
  logic          sof_pend_q;     // next push is the first of the frame
  logic [CW-1:0] line_cnt_q;     // lines completed in the current frame
  logic [CW-1:0] beat_cnt_q;     // beats seen in the current line
  logic [CW-1:0] line_count_q;
  logic [CW-1:0] beat_count_q;
  logic          cam_enable_q;
  logic          cam_request_q;
  logic          frame_done_q;
  logic          overflow_q;

  logic          qual;
  logic          lvv_fall;
  logic          fvv_fall;
  logic          line_end;
  logic          push;
  logic          pop;
  logic          drop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] line_cnt_inc;
  logic [CW-1:0] beat_cnt_inc;
  logic [DW+1:0] fifo_rd;
  beat_t         push_beat;
  beat_t         head_beat;

  assign qual     = (state_q == CAPTURE) & FVV & LVV & VCE;
  assign lvv_fall = (state_q == CAPTURE) & ~LVV & lvv_q;
  assign fvv_fall = (state_q == CAPTURE) & ~FVV & fvv_q;
  // A line only ends if it held at least one beat; an empty line leaves the stage empty.
  assign line_end = skid_vld_q & (lvv_fall | fvv_fall);
  // qual needs LVV and FVV high, so it never coincides with line_end: one push at most.
  assign push     = (qual & skid_vld_q) | line_end;
  assign pop      = out_ready & ~fifo_empty;
  assign drop     = push & fifo_full & ~pop;

  assign line_cnt_inc = CW'(sat_inc(32'(line_cnt_q), CW));
  assign beat_cnt_inc = CW'(sat_inc(32'(beat_cnt_q), CW));

  // Held beat leaves the stage tagged eol only when its line is closing.
  always_comb begin
    push_beat      = '0;
    push_beat.data = skid_dat_q;
    push_beat.sof  = sof_pend_q;
    push_beat.eol  = line_end;
  end

  simbus_sync_fifo #(
    .WIDTH (DW + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i    (CLOCK),
    .rst_i    (RESET),
    .push_i   (push),
    .wr_dat_i (push_beat),
    .full_o   (fifo_full),
    .pop_i    (pop),
    .rd_dat_o (fifo_rd),
    .empty_o  (fifo_empty)
  );

  assign head_beat   = beat_t'(fifo_rd);
  assign out_valid   = ~fifo_empty;
  assign out_data    = head_beat.data;
  assign out_sof     = ~fifo_empty & head_beat.sof;
  assign out_eol     = ~fifo_empty & head_beat.eol;
  assign cam_enable  = cam_enable_q;
  assign cam_request = cam_request_q;
  assign frame_done  = frame_done_q;
  assign line_count  = line_count_q;
  assign beat_count  = beat_count_q;
  assign overflow    = overflow_q;

  // Capture FSM with registered camera controls, skid stage, geometry counters and status flags.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q       <= IDLE;
      fvv_q         <= 1'b0;
      lvv_q         <= 1'b0;
      skid_vld_q    <= 1'b0;
      skid_dat_q    <= '0;
      sof_pend_q    <= 1'b0;
      line_cnt_q    <= '0;
      beat_cnt_q    <= '0;
      line_count_q  <= '0;
      beat_count_q  <= '0;
      cam_enable_q  <= 1'b0;
      cam_request_q <= 1'b0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      fvv_q        <= FVV;
      lvv_q        <= LVV;
      frame_done_q <= 1'b0;
      if (drop) overflow_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (arm) begin
            state_q       <= ARMED;
            cam_enable_q  <= 1'b1;
            cam_request_q <= 1'b1;
            overflow_q    <= 1'b0;
          end
        end
        ARMED: begin
          // Only a true rising edge starts capture; a frame already running is skipped.
          if (FVV && !fvv_q) begin
            state_q       <= CAPTURE;
            cam_request_q <= 1'b0;
            line_cnt_q    <= '0;
            beat_cnt_q    <= '0;
            skid_vld_q    <= 1'b0;
            sof_pend_q    <= 1'b1;
          end
        end
        CAPTURE: begin
          if (qual) begin
            skid_vld_q <= 1'b1;
            skid_dat_q <= pix_in;
            beat_cnt_q <= beat_cnt_inc;
          end
          // sof is consumed by the first push even if the FIFO drops it.
          if (push) sof_pend_q <= 1'b0;
          if (line_end) begin
            skid_vld_q   <= 1'b0;
            beat_count_q <= beat_cnt_q;
            beat_cnt_q   <= '0;
            line_cnt_q   <= line_cnt_inc;
          end
          if (fvv_fall) begin
            line_count_q <= line_end ? line_cnt_inc : line_cnt_q;
            frame_done_q <= 1'b1;
            if (continuous) begin
              state_q       <= ARMED;
              cam_request_q <= 1'b1;
            end else begin
              state_q       <= IDLE;
              cam_enable_q  <= 1'b0;
              cam_request_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cameralink_capture.sv
// tb_cameralink_capture: directed plus randomized frames against a behavioural capture model.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// out_ready is held high, held low, or randomized depending on the phase.
module tb_cameralink_capture;
  localparam int TAPS   = 1;
  localparam int BITS   = 8;
  localparam int DEPTH  = 16;
  localparam int CW     = 16;
  localparam int DW     = TAPS * BITS;
  localparam int SATMAX = (1 << CW) - 1;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b1;
  logic          FVV = 1'b0;
  logic          LVV = 1'b0;
  logic          VCE = 1'b0;
  logic [DW-1:0] pix_in = '0;
  logic          arm = 1'b0;
  logic          continuous = 1'b0;
  logic          out_ready = 1'b1;
  logic          cam_enable;
  logic          cam_request;
  logic [DW-1:0] out_data;
  logic          out_sof;
  logic          out_eol;
  logic          out_valid;
  logic          frame_done;
  logic [CW-1:0] line_count;
  logic [CW-1:0] beat_count;
  logic          overflow;

  cameralink_capture #(.TAPS(TAPS), .BITS(BITS), .DEPTH(DEPTH), .CW(CW)) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .FVV         (FVV),
    .LVV         (LVV),
    .VCE         (VCE),
    .pix_in      (pix_in),
    .arm         (arm),
    .continuous  (continuous),
    .cam_enable  (cam_enable),
    .cam_request (cam_request),
    .out_data    (out_data),
    .out_sof     (out_sof),
    .out_eol     (out_eol),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .frame_done  (frame_done),
    .line_count  (line_count),
    .beat_count  (beat_count),
    .overflow    (overflow)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [DW-1:0] d;
    bit            sof;
    bit            eol;
  } beat_s;

  beat_s fq[$];   // expected output buffer contents
  beat_s rx[$];   // beats actually transferred by the DUT

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit rnd_ready = 1'b0;
  int fd_cnt = 0;
  int dcnt = 0;

  // Model state: mode 0 idle, 1 waiting for a frame, 2 inside a captured frame.
  int            m_mode;
  bit            m_fvd, m_lvd, m_held_v, m_first;
  logic [DW-1:0] m_held;
  int            m_beats, m_lines;
  bit            m_qual, m_lfall, m_ffall;
  int            e_lc, e_bc;
  bit            e_fd, e_ovf;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int x);
    return (x > SATMAX) ? SATMAX : x;
  endfunction

  function automatic void m_push(input logic [DW-1:0] d, input bit eol);
    beat_s b;
    b.d = d;
    b.sof = m_first;
    b.eol = eol;
    if (fq.size() < DEPTH) fq.push_back(b);
    else e_ovf = 1'b1;
    m_first = 1'b0;
  endfunction

  // Behavioural model: a beat is emitted once its successor arrives or its line closes.
  always @(posedge CLOCK) begin
    if (RESET) begin
      m_mode = 0; m_fvd = 0; m_lvd = 0; m_held_v = 0; m_first = 0;
      m_beats = 0; m_lines = 0; e_lc = 0; e_bc = 0; e_fd = 0; e_ovf = 0;
      fq.delete();
    end else begin
      if (fq.size() > 0 && out_ready) void'(fq.pop_front());
      e_fd = 1'b0;
      m_qual  = FVV && LVV && VCE;
      m_lfall = !LVV && m_lvd;
      m_ffall = !FVV && m_fvd;
      if (m_mode == 0) begin
        if (arm) begin m_mode = 1; e_ovf = 1'b0; end
      end else if (m_mode == 1) begin
        if (FVV && !m_fvd) begin
          m_mode = 2; m_lines = 0; m_beats = 0; m_held_v = 0; m_first = 1;
        end
      end else begin
        if (m_qual) begin
          if (m_held_v) m_push(m_held, 1'b0);
          m_held = pix_in; m_held_v = 1'b1; m_beats = sat(m_beats + 1);
        end else if (m_held_v && (m_lfall || m_ffall)) begin
          m_push(m_held, 1'b1);
          m_held_v = 1'b0; e_bc = m_beats; m_beats = 0; m_lines = sat(m_lines + 1);
        end
        if (m_ffall) begin
          e_lc = m_lines; e_fd = 1'b1; m_mode = continuous ? 1 : 0;
        end
      end
      m_fvd = FVV;
      m_lvd = LVV;
    end
  end

  // Per-cycle comparison of every output against the model, plus transfer log.
  always @(negedge CLOCK) begin
    if (chk_en) begin
      chk("out_valid", out_valid, fq.size() > 0);
      if (fq.size() > 0) begin
        chk("out_data", out_data, fq[0].d);
        chk("out_sof", out_sof, fq[0].sof);
        chk("out_eol", out_eol, fq[0].eol);
      end
      chk("frame_done", frame_done, e_fd);
      chk("line_count", line_count, e_lc);
      chk("beat_count", beat_count, e_bc);
      chk("overflow", overflow, e_ovf);
      chk("cam_enable", cam_enable, m_mode != 0);
      chk("cam_request", cam_request, m_mode == 1);
      if (out_valid && out_ready) begin
        beat_s b;
        b.d = out_data; b.sof = out_sof; b.eol = out_eol;
        rx.push_back(b);
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    RESET = 1'b1; FVV = 0; LVV = 0; VCE = 0; arm = 0;
    tick(); tick();
    RESET = 1'b0;
    tick();
  endtask

  task automatic clear_log();
    rx.delete(); fd_cnt = 0; dcnt = 0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0; tick();
  endtask

  // vmode: 0 VCE always 1, 1 VCE 1010..., 2 random VCE. simul drops LVV and FVV together.
  task automatic send_frame(input int nl, input int cpl, input int vmode, input bit simul);
    FVV = 1'b1; LVV = 1'b0; VCE = 1'b0; pix_in = DW'($urandom);
    tick(); tick();
    for (int l = 0; l < nl; l++) begin
      for (int c = 0; c < cpl; c++) begin
        LVV = 1'b1;
        if (vmode == 0) VCE = 1'b1;
        else if (vmode == 1) VCE = ((c % 2) == 0);
        else VCE = 1'($urandom_range(0, 1));
        if (VCE) begin pix_in = DW'(dcnt); dcnt++; end
        else pix_in = DW'($urandom);
        tick();
      end
      if (!(simul && l == nl - 1)) begin
        LVV = 1'b0; VCE = 1'b0; pix_in = DW'($urandom);
        tick(); tick();
      end
    end
    FVV = 1'b0; LVV = 1'b0; VCE = 1'b0;
    tick(); tick(); tick();
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sof", out_sof, 0);
    chk("rst_out_eol", out_eol, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_line_count", line_count, 0);
    chk("rst_beat_count", beat_count, 0);
    chk("rst_cam_enable", cam_enable, 0);
    chk("rst_cam_request", cam_request, 0);

    // Single-shot 3x4 frame.
    clear_log(); out_ready = 1'b1; continuous = 1'b0;
    pulse_arm();
    chk("t1_cam_request_armed", cam_request, 1);
    send_frame(3, 4, 0, 1'b0);
    idle(6);
    chk("t1_nbeats", rx.size(), 12);
    for (int i = 0; i < rx.size() && i < 12; i++) begin
      chk("t1_data", rx[i].d, i);
      chk("t1_sof", rx[i].sof, i == 0);
      chk("t1_eol", rx[i].eol, (i % 4) == 3);
    end
    chk("t1_line_count", line_count, 3);
    chk("t1_beat_count", beat_count, 4);
    chk("t1_frame_done_pulses", fd_cnt, 1);
    chk("t1_idle_cam_enable", cam_enable, 0);

    // Continuous: two frames back to back.
    do_reset(); clear_log(); continuous = 1'b1;
    pulse_arm();
    send_frame(3, 4, 0, 1'b0);
    send_frame(3, 4, 0, 1'b0);
    idle(4);
    chk("t2_nbeats", rx.size(), 24);
    if (rx.size() == 24) begin
      chk("t2_sof_f1", rx[0].sof, 1);
      chk("t2_sof_f2", rx[12].sof, 1);
      chk("t2_data_f2", rx[12].d, 12);
    end
    chk("t2_frame_done_pulses", fd_cnt, 2);
    chk("t2_armed_request", cam_request, 1);
    continuous = 1'b0;

    // VCE toggling inside 8-clock lines.
    do_reset(); clear_log();
    pulse_arm();
    send_frame(3, 8, 1, 1'b0);
    idle(6);
    chk("t3_beat_count", beat_count, 4);
    chk("t3_nbeats", rx.size(), 12);
    for (int i = 0; i < rx.size() && i < 12; i++) chk("t3_data", rx[i].d, i);

    // Overflow with a stalled sink.
    do_reset(); clear_log(); out_ready = 1'b0;
    pulse_arm();
    send_frame(3, 8, 0, 1'b0);
    idle(2);
    chk("t4_overflow", overflow, 1);
    chk("t4_no_output", rx.size(), 0);
    chk("t4_line_count", line_count, 3);
    out_ready = 1'b1;
    idle(20);
    chk("t4_drained", rx.size(), 16);
    for (int i = 0; i < rx.size() && i < 16; i++) chk("t4_data", rx[i].d, i);
    pulse_arm();
    chk("t4_arm_clears_overflow", overflow, 0);

    // LVV and FVV fall together on the last line.
    do_reset(); clear_log();
    pulse_arm();
    send_frame(2, 5, 0, 1'b1);
    idle(6);
    chk("t5_nbeats", rx.size(), 10);
    if (rx.size() == 10) begin
      chk("t5_eol_line1", rx[4].eol, 1);
      chk("t5_eol_last", rx[9].eol, 1);
    end
    chk("t5_line_count", line_count, 2);
    chk("t5_beat_count", beat_count, 5);

    // Reset mid-line, then a clean capture.
    do_reset(); clear_log();
    pulse_arm();
    FVV = 1'b1; tick(); tick();
    LVV = 1'b1; VCE = 1'b1; pix_in = 8'hAA; tick();
    RESET = 1'b1; tick();
    chk("t6_rst_cam_enable", cam_enable, 0);
    chk("t6_rst_out_valid", out_valid, 0);
    RESET = 1'b0;
    repeat (3) tick();
    LVV = 1'b0; VCE = 1'b0; tick();
    FVV = 1'b0; idle(4);
    chk("t6_no_beats", rx.size(), 0);
    chk("t6_no_frame_done", fd_cnt, 0);
    chk("t6_line_count", line_count, 0);
    clear_log();
    pulse_arm();
    send_frame(2, 3, 0, 1'b0);
    idle(6);
    chk("t6_nbeats", rx.size(), 6);
    for (int i = 0; i < rx.size() && i < 6; i++) chk("t6_data", rx[i].d, i);
    chk("t6_line_count_after", line_count, 2);

    // Randomized geometry, VCE, sink readiness and re-arm mode.
    do_reset(); clear_log(); rnd_ready = 1'b1;
    repeat (10) begin
      continuous = 1'($urandom_range(0, 1));
      pulse_arm();
      send_frame($urandom_range(1, 4), $urandom_range(1, 10), 2, 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 3));
    end
    rnd_ready = 1'b0; out_ready = 1'b1;
    idle(25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
